// File: rtl/dm_wait_bank_pkg.sv
// Shared types and constants for the dm_wait_bank data memory.
// The DM_PRELOAD_EN build option uses the preload table defined here.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } dm_state_e;

  localparam int PRELOAD_N = 5;
  localparam int PRELOAD_VAL [PRELOAD_N] = '{17, 31, -5, -2, 250};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dm_ram_array.sv
// Single-port DEPTH x DATA_W RAM with byte-lane synchronous write and registered read.
// With DM_PRELOAD_EN defined, words 0..4 start with the dm_pkg preload table and all others start at 0.
module dm_ram_array
  import dm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

`ifdef DM_PRELOAD_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
    for (int i = 0; i < PRELOAD_N; i++) r_mem[i] = DATA_W'(PRELOAD_VAL[i]);
  end
`endif

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < LANES; i++) begin
          if (i_be[i]) r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_wait_bank.sv
// MEM-stage data memory: req/ready handshake, programmable wait states, byte strobes, error response.
// The build option DM_PRELOAD_EN (handled in dm_ram_array) selects the preloaded initial contents.
module dm_wait_bank
  import dm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  output logic                o_ready,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_resp_err
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = clog2(LANES);
  localparam int IDX_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  localparam logic [3:0]        CNT_INIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  dm_state_e           r_state;
  dm_state_e           w_state_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LANES-1:0]    r_be;
  logic                r_load_ok;
  logic                r_resp_err;

  logic [ADDR_W-1:0]   w_index;
  logic                w_err;
  logic                w_accept;
  logic                w_ram_en;
  logic [DATA_W-1:0]   w_ram_rdata;

  assign w_index  = r_addr >> LANE_W;
  assign w_err    = ((r_addr & LANE_MASK) != '0) || (w_index >= DEPTH_A);
  assign w_accept = (r_state == StIdle) && i_req;
  // Rejected accesses never touch the array, so a bad store cannot corrupt memory.
  assign w_ram_en = (r_state == StAccess) && !w_err;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_req) w_state_next = (WAIT_CYCLES > 0) ? StWait : StAccess;
      StWait:   if (r_cnt == 4'd0) w_state_next = StAccess;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_load_ok  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_be    <= i_be;
        r_cnt   <= CNT_INIT;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response flags change only on the edge entering RESP, so they hold until the next one.
      if (r_state == StAccess) begin
        r_load_ok  <= !r_we && !w_err;
        r_resp_err <= w_err;
      end
    end
  end

  dm_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (r_we),
    .i_addr  (w_index[IDX_W-1:0]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_ram_rdata)
  );

  assign o_ready      = (r_state == StIdle);
  assign o_resp_valid = (r_state == StResp);
  assign o_rdata      = r_load_ok ? w_ram_rdata : '0;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_wait_bank.sv
// Self-checking bench for dm_wait_bank: two instances (no wait states and 3 wait states)
// checked against a word-array reference model.
module tb_dm_wait_bank;

  localparam int DEPTH = 64;
  localparam int W1    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]       req, we, ready, resp_valid, resp_err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  be;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;

  dm_wait_bank #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_req(req[0]), .o_ready(ready[0]), .i_we(we[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .i_be(be[0]), .o_resp_valid(resp_valid[0]),
    .o_rdata(rdata[0]), .o_resp_err(resp_err[0])
  );

  dm_wait_bank #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(W1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req[1]), .o_ready(ready[1]), .i_we(we[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .i_be(be[1]), .o_resp_valid(resp_valid[1]),
    .o_rdata(rdata[1]), .o_resp_err(resp_err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : W1;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // Reference model: applies one access to the word array and returns the expected response.
  function automatic void model_op(input int d, input logic w, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] b,
                                   output logic [31:0] erd, output logic eer);
    int idx;
    eer = is_err(a);
    erd = 32'h0;
    if (!eer) begin
      idx = int'(a >> 2);
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        erd = model[d][idx];
      end
    end
  endfunction

  // Drives one access on instance d and reports response and protocol observations.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input bit pulse_busy, output logic [31:0] rd,
                        output logic er, output int lat, output bit proto_ok);
    int n;
    proto_ok = 1'b1;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    n = 0;
    while (ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) proto_ok = 1'b0;
    @(negedge clk);
    req[d] = 1'b0;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      if (ready[d] !== 1'b0) proto_ok = 1'b0;
      if (pulse_busy) begin
        req[d]  = 1'($urandom_range(0, 1));
        we[d]   = 1'($urandom_range(0, 1));
        addr[d] = {$urandom_range(0, DEPTH - 1), 2'b00};
        wdata[d] = $urandom;
        be[d]   = 4'hF;
      end
      @(negedge clk);
      lat++;
    end
    req[d] = 1'b0;
    if (resp_valid[d] !== 1'b1) begin
      proto_ok = 1'b0;
      lat = -1;
    end
    if (ready[d] !== 1'b0) proto_ok = 1'b0;
    rd = rdata[d];
    er = resp_err[d];
    @(negedge clk);
    if (resp_valid[d] !== 1'b0 || ready[d] !== 1'b1) proto_ok = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || rdata[d] !== 32'h0 ||
          resp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset d=%0d got ready=%b rv=%b rdata=%h err=%b want 1 0 0 0",
                 d, ready[d], resp_valid[d], rdata[d], resp_err[d]);
      end
    end
  endtask

`ifdef DM_PRELOAD_EN
  task automatic test_preload();
    logic [31:0] rd; logic er; int lat; bit ok;
    access(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    checks++;
    if (rd !== 32'hFFFF_FFFB || er !== 1'b0 || lat != 2 || !ok) begin
      errors++;
      $display("FAIL preload got rdata=%h err=%b lat=%0d ok=%b want fffffffb 0 2 1",
               rd, er, lat, ok);
    end
  endtask
`endif

  task automatic test_fill();
    logic [31:0] rd, erd, v; logic er, eer; int lat; bit ok;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        v = $urandom;
        model_op(d, 1'b1, 32'(i * 4), v, 4'hF, erd, eer);
        access(d, 1'b1, 32'(i * 4), v, 4'hF, 1'b0, rd, er, lat, ok);
        checks++;
        if (er !== eer || rd !== erd || lat != wait_of(d) + 2 || !ok) begin
          errors++;
          $display("FAIL fill d=%0d i=%0d got err=%b rdata=%h lat=%0d ok=%b want %b %h %0d 1",
                   d, i, er, rd, lat, ok, eer, erd, wait_of(d) + 2);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
    for (int d = 0; d < 2; d++) begin
      model_op(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, erd, eer);
      access(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat, ok);
      access(d, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != wait_of(d) + 2 || !ok) begin
        errors++;
        $display("FAIL full_store d=%0d got rdata=%h err=%b lat=%0d want deadbeef 0 %0d",
                 d, rd, er, lat, wait_of(d) + 2);
      end
      model_op(d, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, erd, eer);
      access(d, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 1'b0, rd, er, lat, ok);
      model_op(d, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, erd, eer);
      access(d, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL be0_store d=%0d got err=%b rdata=%h want 0 0", d, er, rd);
      end
      access(d, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      checks++;
      if (rd !== 32'hDEAD_AAEF || er !== 1'b0 || !ok) begin
        errors++;
        $display("FAIL lane_store d=%0d got rdata=%h err=%b want deadaaef 0", d, rd, er);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit ok;
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 32'h6, 32'h0, 4'hF, 1'b0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || !ok) begin
        errors++;
        $display("FAIL misaligned_load d=%0d got err=%b rdata=%h want 1 0", d, er, rd);
      end
      access(d, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er, lat, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || !ok) begin
        errors++;
        $display("FAIL misaligned_store d=%0d got err=%b rdata=%h want 1 0", d, er, rd);
      end
      access(d, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      checks++;
      if (rd !== model[d][1] || er !== 1'b0) begin
        errors++;
        $display("FAIL word1_kept d=%0d got rdata=%h err=%b want %h 0", d, rd, er, model[d][1]);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [31:0] rd; logic er; int lat; bit ok; int stray;
    access(1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
    checks++;
    if (lat != W1 + 2 || er !== 1'b1 || rd !== 32'h0 || !ok) begin
      errors++;
      $display("FAIL out_of_range got lat=%0d err=%b rdata=%h ok=%b want %0d 1 0 1",
               lat, er, rd, ok, W1 + 2);
    end
    stray = 0;
    repeat (W1 + 4) begin
      @(negedge clk);
      if (resp_valid[1] !== 1'b0 || ready[1] !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL busy_req_ignored got %0d stray busy/resp cycles want 0", stray);
    end
    for (int i = 0; i < DEPTH; i += 9) begin
      access(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
      checks++;
      if (rd !== model[1][i] || er !== 1'b0) begin
        errors++;
        $display("FAIL busy_no_write i=%0d got %h want %h", i, rd, model[1][i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, v; logic er, eer, w; logic [3:0] b; int lat; bit ok; int sel;
    for (int n = 0; n < 160; n++) begin
      int d;
      d = n % 2;
      sel = $urandom_range(0, 9);
      a = {$urandom_range(0, DEPTH - 1), 2'b00};
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = a + 32'(DEPTH * 4) + (32'($urandom_range(0, 1)) << 30);
      w = 1'($urandom_range(0, 1));
      v = $urandom;
      b = 4'($urandom_range(0, 15));
      model_op(d, w, a, v, b, erd, eer);
      access(d, w, a, v, b, 1'b0, rd, er, lat, ok);
      checks++;
      if (rd !== erd || er !== eer || lat != wait_of(d) + 2 || !ok) begin
        errors++;
        $display("FAIL random n=%0d d=%0d we=%b a=%h got %h/%b/%0d/%b want %h/%b/%0d/1",
                 n, d, w, a, rd, er, lat, ok, erd, eer, wait_of(d) + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last, gap_bad, pulses, data_bad;
    for (int d = 0; d < 2; d++) begin
      last = -1; gap_bad = 0; pulses = 0; data_bad = 0;
      @(negedge clk);
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'h10; be[d] = 4'h0;
      for (int c = 0; c < 4 * (wait_of(d) + 3) + 2; c++) begin
        @(negedge clk);
        if (resp_valid[d] === 1'b1) begin
          if (last >= 0 && c - last != wait_of(d) + 3) gap_bad++;
          if (rdata[d] !== model[d][4]) data_bad++;
          last = c;
          pulses++;
        end
      end
      req[d] = 1'b0;
      repeat (wait_of(d) + 4) @(negedge clk);
      checks++;
      if (pulses < 3 || gap_bad != 0 || data_bad != 0) begin
        errors++;
        $display("FAIL back_to_back d=%0d got pulses=%0d bad_gaps=%0d bad_data=%0d want >=3 0 0",
                 d, pulses, gap_bad, data_bad);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd, old; logic er; int lat; bit ok;
    old = model[1][0];
    access(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'h1234_5678; be[1] = 4'hF;
    @(negedge clk);
    req[1] = 1'b0;
    checks++;
    if (ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL store_in_wait got ready=%b want 0", ready[1]);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || rdata[1] !== 32'h0 ||
        resp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got ready=%b rv=%b rdata=%h err=%b want 1 0 0 0",
               ready[1], resp_valid[1], rdata[1], resp_err[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat, ok);
    checks++;
    if (rd !== old || er !== 1'b0 || lat != W1 + 2 || !ok) begin
      errors++;
      $display("FAIL dropped_store got rdata=%h err=%b lat=%0d want %h 0 %0d",
               rd, er, lat, old, W1 + 2);
    end
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
`ifdef DM_PRELOAD_EN
    test_preload();
`endif
    test_fill();
    test_store_load();
    test_errors();
    test_busy_ignored();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
